// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PcW = 32;

  // Instruction word field positions
  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned TargetMsb = 25;
  localparam int unsigned TargetLsb = 0;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic {
    FETCH   = 1'b0,
    DELIVER = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump/jal, conditional branch, or sequential PC+4.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned IMM_W = 16
) (
  input  logic [PcW-1:0]   pc_i,
  input  logic             branch_i,
  input  logic             branch_ne_i,
  input  logic             jump_i,
  input  logic             jal_i,
  input  logic             alu_zero_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [25:0]      target_i,
  output logic [PcW-1:0]   pc_plus4_o,
  output logic [PcW-1:0]   next_pc_o
);

  logic [PcW-1:0] pc_plus4;
  logic [PcW-1:0] imm_sext;
  logic           taken;

  always_comb begin
    pc_plus4 = pc_i + 32'd4;
    imm_sext = {{(PcW - IMM_W){imm_i[IMM_W-1]}}, imm_i};
    // Setting both branch flags takes the branch on either condition
    taken    = (branch_i & alu_zero_i) | (branch_ne_i & ~alu_zero_i);
    if (jump_i || jal_i) begin
      next_pc_o = {pc_plus4[PcW-1:PcW-4], target_i, 2'b00};
    end else if (taken) begin
      next_pc_o = pc_plus4 + {imm_sext[PcW-3:0], 2'b00};
    end else begin
      next_pc_o = pc_plus4;
    end
    pc_plus4_o = pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: request from imem, then hand the word to decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMM_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch,
  input  logic             branch_ne,
  input  logic             jump,
  input  logic             jal,
  input  logic             alu_zero,
  input  logic [IMM_W-1:0] imm16,
  input  logic [25:0]      target26,
  output logic [31:0]      link_addr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);

  fetch_state_e   state_q, state_d;
  logic [PcW-1:0] pc_q, pc_d;
  logic [31:0]    instr_q, instr_d;
  logic [PcW-1:0] link_q, link_d;
  logic [PcW-1:0] pc_plus4;
  logic [PcW-1:0] next_pc;

  fetch_next_pc #(
    .IMM_W(IMM_W)
  ) u_next_pc (
    .pc_i        (pc_q),
    .branch_i    (branch),
    .branch_ne_i (branch_ne),
    .jump_i      (jump),
    .jal_i       (jal),
    .alu_zero_i  (alu_zero),
    .imm_i       (imm16),
    .target_i    (target26),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    link_d      = link_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          link_d  = pc_plus4;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        // Control inputs only matter here, on the handshake
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      link_q  <= link_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign link_addr = link_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (instr_valid && instr_ready) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (imem_req && !imem_ack)      perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter IMM_W, default 16, SHALL be the branch offset width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 imem_req  output  1  SHALL be the instruction memory request, held until acknowledged.
REQ-006 imem_addr  output  32  SHALL be the fetch address (current PC).
REQ-007 imem_ack  input  1  SHALL mark imem_rdata valid and complete the request.
REQ-008 imem_rdata  input  32  SHALL be the instruction word.
REQ-009 instr  output  32  SHALL be the fetched instruction; instr[31:26] feeds the opcode decoder.
REQ-010 instr_valid  output  1  SHALL mark instr and link_addr valid for decode.
REQ-011 instr_ready  input  1  SHALL mark that decode accepts instr this cycle.
REQ-012 branch, branch_ne, jump, jal  input  1 each  SHALL be the decoded control for the instruction being handed over.
REQ-013 alu_zero  input  1  SHALL be the resolved compare result for that instruction.
REQ-014 imm16  input  IMM_W  SHALL be the branch word offset; target26  input  26  SHALL be the jump index.
REQ-015 link_addr  output  32  SHALL be PC+4 of the held instruction, used as the jal return address.

Function
REQ-016 The FSM SHALL have exactly two states: FETCH (imem_req=1) and DELIVER (instr_valid=1).
REQ-017 In FETCH, imem_req and imem_addr SHALL stay stable until imem_ack; ack captures imem_rdata into instr and moves to DELIVER next cycle.
REQ-018 Minimum latency SHALL be one cycle from ack to instr_valid; peak throughput SHALL be one instruction per two cycles.
REQ-019 In DELIVER, instr, instr_valid and link_addr SHALL hold stable until instr_ready=1.
REQ-020 On the handshake cycle (instr_valid & instr_ready), PC SHALL load next_pc and the state SHALL return to FETCH.
REQ-021 next_pc priority: jump|jal -> {pc_plus4[31:28], target26, 2'b00}; else (branch & alu_zero) | (branch_ne & ~alu_zero) -> pc_plus4 + (sign-extended imm16 << 2); else pc_plus4.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
REQ-023 Control and imm/target inputs SHALL be ignored on every cycle except the handshake cycle.
REQ-024 imem_ack in DELIVER SHALL be ignored.
REQ-025 branch and branch_ne both high SHALL take the branch whenever either condition is true.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set the state to FETCH, PC=RESET_PC, instr=0, instr_valid=0, link_addr=0.
REQ-027 imem_req SHALL be 1 in the first cycle after reset release, with imem_addr=RESET_PC.
REQ-028 Reset mid-request or mid-delivery SHALL abandon the transaction; an ack arriving in the reset cycle SHALL be discarded.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: outputs perf_fetched (32) and perf_stall (32) SHALL exist and be cleared by reset; perf_fetched increments on each handshake and perf_stall on each cycle with imem_req & ~imem_ack; both wrap at 2^32.
REQ-030 Macro FETCH_PERF_CNT_EN undefined: neither those ports nor the counters SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum (FETCH, DELIVER), the PC width constant (32) and the instruction field positions (opcode 31:26, target 25:0, imm 15:0).
REQ-032 Combinational sub-module fetch_next_pc SHALL compute pc_plus4 and next_pc; the FSM and registers SHALL stay in fetch_unit.

Verification
REQ-033 Reset release with ack tied high -> imem_addr 0, then 4, then 8; instr_valid every second cycle.
REQ-034 At PC=0x10, beq with alu_zero=1 and imm16=0xFFFF -> next imem_addr 0x10.
REQ-035 At PC=0x10, bne with alu_zero=1 -> next imem_addr 0x14.
REQ-036 At PC=0x4000_0000, jal with target26=0x100 -> link_addr 0x4000_0004, next imem_addr 0x4000_0400.
REQ-037 instr_ready low for 5 cycles in DELIVER -> instr and link_addr stable, imem_req=0 throughout; rst_n low during FETCH with an ack in the same cycle -> ack discarded, next imem_addr = RESET_PC.
REQ-038 With FETCH_PERF_CNT_EN defined, 3 fetches each with 2 wait cycles -> perf_fetched=3, perf_stall=6.
